// File: rtl/demux16_1to4_buf.sv
// demux16_1to4_buf: steers bus words into four per-destination FIFOs,
// each drained through its own valid/ready handshake.
module demux16_1to4_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Din,
  input  logic [1:0]       sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] D_out_A,
  output logic [WIDTH-1:0] D_out_B,
  output logic [WIDTH-1:0] D_out_C,
  output logic [WIDTH-1:0] D_out_D,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [CW-1:0]    count_A,
  output logic [CW-1:0]    count_B,
  output logic [CW-1:0]    count_C,
  output logic [CW-1:0]    count_D
);
  logic [WIDTH-1:0] r_mem [4][DEPTH];
  logic [PW-1:0]    r_rd  [4];
  logic [PW-1:0]    r_wr  [4];
  logic [CW-1:0]    r_cnt [4];
  logic [3:0]       w_push;
  logic [3:0]       w_pop;
  logic [WIDTH-1:0] w_head [4];

  // A full FIFO refuses the push even when it pops this cycle: no pass-through.
  assign in_ready = r_cnt[sel] != CW'(DEPTH);

  for (genvar g = 0; g < 4; g++) begin : g_q
    assign w_push[g]    = in_valid && in_ready && (sel == 2'(g));
    assign w_pop[g]     = out_ready[g] && (r_cnt[g] != '0);
    assign out_valid[g] = r_cnt[g] != '0;
    assign w_head[g]    = (r_cnt[g] != '0) ? r_mem[g][r_rd[g]] : '0;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 4; i++) begin
        r_rd[i]  <= '0;
        r_wr[i]  <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_push[i]) r_wr[i] <= r_wr[i] + PW'(1);
        if (w_pop[i]) r_rd[i] <= r_rd[i] + PW'(1);
        r_cnt[i] <= (w_push[i] && !w_pop[i]) ? r_cnt[i] + CW'(1) :
                    (!w_push[i] && w_pop[i]) ? r_cnt[i] - CW'(1) : r_cnt[i];
      end
    end
  end

  // Storage is not reset; the cleared counts mask whatever it holds.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < 4; i++)
      if (w_push[i]) r_mem[i][r_wr[i]] <= Din;
  end

  assign D_out_A = w_head[0];
  assign D_out_B = w_head[1];
  assign D_out_C = w_head[2];
  assign D_out_D = w_head[3];
  assign count_A = r_cnt[0];
  assign count_B = r_cnt[1];
  assign count_C = r_cnt[2];
  assign count_D = r_cnt[3];
endmodule

// File: tb/tb_demux16_1to4_buf.sv
// tb_demux16_1to4_buf: directed checks of steering, backpressure, wrap and reset.
module tb_demux16_1to4_buf;
  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] Din = '0;
  logic [1:0]  sel = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] D_out_A, D_out_B, D_out_C, D_out_D;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = '0;
  logic [1:0]  count_A, count_B, count_C, count_D;
  int checks = 0;
  int errors = 0;

  demux16_1to4_buf #(.WIDTH(16), .DEPTH(2)) dut (
    .Clk(Clk), .Reset(Reset), .Din(Din), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .D_out_A(D_out_A), .D_out_B(D_out_B),
    .D_out_C(D_out_C), .D_out_D(D_out_D), .out_valid(out_valid),
    .out_ready(out_ready), .count_A(count_A), .count_B(count_B),
    .count_C(count_C), .count_D(count_D)
  );

  always #5 Clk = ~Clk;

  task automatic test_reset;
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_held got %b exp 1", in_ready); end
    Reset = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL rst_out_valid got %b exp 0000", out_valid); end
    checks++; if ({D_out_A, D_out_B, D_out_C, D_out_D} !== 64'h0) begin errors++; $display("FAIL rst_dout got %h exp 0", {D_out_A, D_out_B, D_out_C, D_out_D}); end
    checks++; if ({count_A, count_B, count_C, count_D} !== 8'h00) begin errors++; $display("FAIL rst_counts got %h exp 00", {count_A, count_B, count_C, count_D}); end
    out_ready = 4'hF;
    @(negedge Clk);
    out_ready = 4'h0;
    checks++; if ({count_A, count_B, count_C, count_D} !== 8'h00) begin errors++; $display("FAIL empty_pop_counts got %h exp 00", {count_A, count_B, count_C, count_D}); end
  endtask

  task automatic test_steering;
    logic [15:0] vals [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      Din = vals[i];
      @(negedge Clk);
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 4'b1111) begin errors++; $display("FAIL steer_valid got %b exp 1111", out_valid); end
    checks++; if (D_out_A !== 16'h1111) begin errors++; $display("FAIL steer_A got %h exp 1111", D_out_A); end
    checks++; if (D_out_B !== 16'h2222) begin errors++; $display("FAIL steer_B got %h exp 2222", D_out_B); end
    checks++; if (D_out_C !== 16'h3333) begin errors++; $display("FAIL steer_C got %h exp 3333", D_out_C); end
    checks++; if (D_out_D !== 16'h4444) begin errors++; $display("FAIL steer_D got %h exp 4444", D_out_D); end
    checks++; if ({count_A, count_B, count_C, count_D} !== 8'h55) begin errors++; $display("FAIL steer_counts got %h exp 55", {count_A, count_B, count_C, count_D}); end
    out_ready = 4'hF;
    @(negedge Clk);
    out_ready = 4'h0;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL steer_drain got %b exp 0000", out_valid); end
  endtask

  task automatic test_full;
    sel = 2'd1;
    in_valid = 1'b1;
    Din = 16'hA001;
    @(negedge Clk);
    Din = 16'hA002;
    @(negedge Clk);
    in_valid = 1'b0;
    checks++; if (count_B !== 2'd2) begin errors++; $display("FAIL full_countB got %0d exp 2", count_B); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready_B got %b exp 0", in_ready); end
    in_valid = 1'b1;
    Din = 16'hDEAD;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready_B_valid got %b exp 0", in_ready); end
    @(negedge Clk);
    in_valid = 1'b0;
    checks++; if (count_B !== 2'd2) begin errors++; $display("FAIL full_no_push got %0d exp 2", count_B); end
    checks++; if (D_out_B !== 16'hA001) begin errors++; $display("FAIL full_head1 got %h exp a001", D_out_B); end
    sel = 2'd0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_A got %b exp 1", in_ready); end
    sel = 2'd1;
    out_ready = 4'b0010;
    @(negedge Clk);
    out_ready = 4'b0000;
    checks++; if (D_out_B !== 16'hA002) begin errors++; $display("FAIL full_head2 got %h exp a002", D_out_B); end
    checks++; if (count_B !== 2'd1) begin errors++; $display("FAIL full_pop1 got %0d exp 1", count_B); end
    out_ready = 4'b0010;
    @(negedge Clk);
    out_ready = 4'b0000;
    checks++; if (count_B !== 2'd0) begin errors++; $display("FAIL full_pop2 got %0d exp 0", count_B); end
    checks++; if (out_valid !== 4'b0000 || D_out_B !== 16'h0) begin errors++; $display("FAIL full_empty got %b/%h exp 0000/0000", out_valid, D_out_B); end
  endtask

  task automatic test_simul;
    sel = 2'd2;
    in_valid = 1'b1;
    Din = 16'h1234;
    @(negedge Clk);
    Din = 16'hC0DE;
    out_ready = 4'b0100;
    @(negedge Clk);
    in_valid = 1'b0;
    out_ready = 4'b0000;
    checks++; if (count_C !== 2'd1) begin errors++; $display("FAIL sim_countC got %0d exp 1", count_C); end
    checks++; if (D_out_C !== 16'hC0DE) begin errors++; $display("FAIL sim_headC got %h exp c0de", D_out_C); end
    in_valid = 1'b1;
    Din = 16'h5555;
    @(negedge Clk);
    checks++; if (count_C !== 2'd2) begin errors++; $display("FAIL sim_fullC got %0d exp 2", count_C); end
    Din = 16'hBEEF;
    out_ready = 4'b0100;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sim_no_passthru got %b exp 0", in_ready); end
    @(negedge Clk);
    out_ready = 4'b0000;
    checks++; if (count_C !== 2'd1) begin errors++; $display("FAIL sim_full_pop got %0d exp 1", count_C); end
    checks++; if (D_out_C !== 16'h5555) begin errors++; $display("FAIL sim_head_after got %h exp 5555", D_out_C); end
    @(negedge Clk);
    in_valid = 1'b0;
    checks++; if (count_C !== 2'd2) begin errors++; $display("FAIL sim_later_push got %0d exp 2", count_C); end
    out_ready = 4'b0100;
    @(negedge Clk);
    checks++; if (D_out_C !== 16'hBEEF) begin errors++; $display("FAIL sim_order got %h exp beef", D_out_C); end
    @(negedge Clk);
    out_ready = 4'b0000;
    checks++; if (count_C !== 2'd0) begin errors++; $display("FAIL sim_drain got %0d exp 0", count_C); end
  endtask

  task automatic test_wrap;
    sel = 2'd3;
    in_valid = 1'b1;
    Din = 16'd0;
    @(negedge Clk);
    for (int k = 1; k < 10; k++) begin
      checks++; if (D_out_D !== 16'(k - 1) || count_D !== 2'd1) begin errors++; $display("FAIL wrap_%0d got %h/%0d exp %h/1", k - 1, D_out_D, count_D, 16'(k - 1)); end
      Din = 16'(k);
      out_ready = 4'b1000;
      @(negedge Clk);
    end
    in_valid = 1'b0;
    checks++; if (D_out_D !== 16'd9 || count_D !== 2'd1) begin errors++; $display("FAIL wrap_9 got %h/%0d exp 0009/1", D_out_D, count_D); end
    @(negedge Clk);
    out_ready = 4'b0000;
    checks++; if (count_D !== 2'd0) begin errors++; $display("FAIL wrap_drain got %0d exp 0", count_D); end
    checks++; if (count_A !== 2'd0) begin errors++; $display("FAIL wrap_A_untouched got %0d exp 0", count_A); end
  endtask

  task automatic test_reset_mid;
    sel = 2'd0;
    in_valid = 1'b1;
    Din = 16'h0011;
    @(negedge Clk);
    Din = 16'h0022;
    @(negedge Clk);
    in_valid = 1'b0;
    checks++; if (count_A !== 2'd2) begin errors++; $display("FAIL mid_fillA got %0d exp 2", count_A); end
    #2 Reset = 1'b0;
    #1;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL mid_async_valid got %b exp 0000", out_valid); end
    checks++; if (count_A !== 2'd0 || D_out_A !== 16'h0) begin errors++; $display("FAIL mid_async_A got %0d/%h exp 0/0000", count_A, D_out_A); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", in_ready); end
    @(negedge Clk);
    Reset = 1'b1;
    in_valid = 1'b1;
    Din = 16'h7777;
    @(negedge Clk);
    in_valid = 1'b0;
    checks++; if (D_out_A !== 16'h7777 || count_A !== 2'd1) begin errors++; $display("FAIL mid_first_push got %h/%0d exp 7777/1", D_out_A, count_A); end
  endtask

  initial begin
    test_reset();
    test_steering();
    test_full();
    test_simul();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
